// File: rtl/turn_sequencer.sv
// Turn sequencer for a match-3 board: cursor/select handling, then the swap/check/elim/drop/revert handshakes.
// Optional COMBO_SCORE_EN weights each match by its cascade depth (match_count*(cascade+1)).
module turn_sequencer #(
    parameter int BOARD_N     = 8,
    parameter int MAX_CASCADE = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [3:0]  op_code,
    output logic [3:0]  x,
    output logic [3:0]  y,
    output logic        selected,
    output logic [3:0]  swap_op,
    output logic        swap_start,
    input  logic        swap_done,
    input  logic        moved,
    output logic        match_start,
    input  logic        match_done,
    input  logic        match_found,
    input  logic [5:0]  match_count,
    output logic        elim_start,
    output logic        drop_start,
    output logic        revert_start,
    input  logic        elim_done,
    input  logic        drop_done,
    input  logic        revert_done,
    output logic [15:0] score,
    output logic        busy
);

    localparam int CW = (MAX_CASCADE < 2) ? 1 : $clog2(MAX_CASCADE + 1);
    localparam logic [3:0]    EDGE    = 4'(BOARD_N - 1);
    localparam logic [CW-1:0] CAS_MAX = CW'(MAX_CASCADE);

    typedef enum logic [2:0] {IDLE, SWAP, CHECK, ELIM, DROP, REVERT} state_t;

    state_t        state, state_n;
    logic [3:0]    x_n, y_n, swap_op_n, save_x, save_y, save_x_n, save_y_n;
    logic          selected_n;
    logic [CW-1:0] cascade, cascade_n;
    logic [15:0]   score_n, add;
    logic [16:0]   sum;
    logic          swap_start_n, match_start_n, elim_start_n, drop_start_n, revert_start_n;
    logic          is_dir;

    // Saturating one-cell move: 1 up (y-1), 2 down (y+1), 3 left (x-1), 4 right (x+1).
    function automatic logic [7:0] step_cursor(input logic [3:0] cx, input logic [3:0] cy,
                                               input logic [3:0] op);
        logic [3:0] nx, ny;
        nx = cx;
        ny = cy;
        case (op)
            4'd1:    if (cy != 4'd0) ny = cy - 4'd1;
            4'd2:    if (cy != EDGE) ny = cy + 4'd1;
            4'd3:    if (cx != 4'd0) nx = cx - 4'd1;
            4'd4:    if (cx != EDGE) nx = cx + 4'd1;
            default: ;
        endcase
        return {nx, ny};
    endfunction

    assign busy   = (state != IDLE);
    assign is_dir = (op_code >= 4'd1) && (op_code <= 4'd4);

    always_comb begin
`ifdef COMBO_SCORE_EN
        add = 16'(match_count) * (16'(cascade) + 16'd1);
`else
        add = {10'd0, match_count};
`endif
        sum = {1'b0, score} + {1'b0, add};
    end

    // Done inputs are only honoured once the matching start pulse has dropped.
    always_comb begin
        state_n        = state;
        x_n            = x;
        y_n            = y;
        selected_n     = selected;
        swap_op_n      = swap_op;
        save_x_n       = save_x;
        save_y_n       = save_y;
        cascade_n      = cascade;
        score_n        = score;
        swap_start_n   = 1'b0;
        match_start_n  = 1'b0;
        elim_start_n   = 1'b0;
        drop_start_n   = 1'b0;
        revert_start_n = 1'b0;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    if (op_code == 4'd5) begin
                        selected_n = ~selected;
                    end else if (is_dir && !selected) begin
                        {x_n, y_n} = step_cursor(x, y, op_code);
                    end else if (is_dir) begin
                        swap_op_n    = op_code;
                        save_x_n     = x;
                        save_y_n     = y;
                        state_n      = SWAP;
                        swap_start_n = 1'b1;
                    end
                end
            end
            SWAP: begin
                if (swap_done && !swap_start) begin
                    selected_n = 1'b0;
                    if (moved) begin
                        {x_n, y_n}    = step_cursor(x, y, swap_op);
                        cascade_n     = '0;
                        state_n       = CHECK;
                        match_start_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            CHECK: begin
                if (match_done && !match_start) begin
                    if (match_found) begin
                        score_n      = sum[16] ? 16'hFFFF : sum[15:0];
                        state_n      = ELIM;
                        elim_start_n = 1'b1;
                    end else if (cascade == '0) begin
                        state_n        = REVERT;
                        revert_start_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            ELIM: begin
                if (elim_done && !elim_start) begin
                    state_n      = DROP;
                    drop_start_n = 1'b1;
                end
            end
            DROP: begin
                if (drop_done && !drop_start) begin
                    if (cascade >= CAS_MAX) begin
                        state_n = IDLE;
                    end else begin
                        cascade_n     = cascade + 1'b1;
                        state_n       = CHECK;
                        match_start_n = 1'b1;
                    end
                end
            end
            REVERT: begin
                if (revert_done && !revert_start) begin
                    x_n     = save_x;
                    y_n     = save_y;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            selected     <= 1'b0;
            swap_op      <= '0;
            save_x       <= '0;
            save_y       <= '0;
            cascade      <= '0;
            score        <= '0;
            swap_start   <= 1'b0;
            match_start  <= 1'b0;
            elim_start   <= 1'b0;
            drop_start   <= 1'b0;
            revert_start <= 1'b0;
        end else begin
            state        <= state_n;
            x            <= x_n;
            y            <= y_n;
            selected     <= selected_n;
            swap_op      <= swap_op_n;
            save_x       <= save_x_n;
            save_y       <= save_y_n;
            cascade      <= cascade_n;
            score        <= score_n;
            swap_start   <= swap_start_n;
            match_start  <= match_start_n;
            elim_start   <= elim_start_n;
            drop_start   <= drop_start_n;
            revert_start <= revert_start_n;
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// Scoreboarded bench for turn_sequencer: a turn-level model predicts start pulses and end-of-turn state.
// Build with COMBO_SCORE_EN defined to check the cascade-weighted scoring.
module tb_turn_sequencer;

    localparam int BN   = 8;
    localparam int MAXC = 15;

    logic        clk = 1'b0, rst_n = 1'b0, op_valid = 1'b0;
    logic [3:0]  op_code = '0;
    logic [3:0]  x, y, swap_op;
    logic        selected, busy;
    logic        swap_start, match_start, elim_start, drop_start, revert_start;
    logic        swap_done = 0, moved = 0, match_done = 0, match_found = 0;
    logic [5:0]  match_count = '0;
    logic        elim_done = 0, drop_done = 0, revert_done = 0;
    logic [15:0] score;

    turn_sequencer #(.BOARD_N(BN), .MAX_CASCADE(MAXC)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
        .x(x), .y(y), .selected(selected), .swap_op(swap_op),
        .swap_start(swap_start), .swap_done(swap_done), .moved(moved),
        .match_start(match_start), .match_done(match_done), .match_found(match_found),
        .match_count(match_count), .elim_start(elim_start), .drop_start(drop_start),
        .revert_start(revert_start), .elim_done(elim_done), .drop_done(drop_done),
        .revert_done(revert_done), .score(score), .busy(busy)
    );

    always #5 clk = ~clk;

    // Event kinds: 0 swap, 1 match, 2 elim, 3 drop, 4 revert (start pulses), 5 end of turn.
    typedef struct {int kind; int ex; int ey; int eop; int escore;} ev_t;
    typedef struct {int kind; bit r1; logic [5:0] cnt;} drv_t;

    ev_t  expq[$];
    drv_t drv[$];
    int   total = 0, bad = 0;
    int   mx = 0, my = 0, mscore = 0;
    bit   msel = 0, tmo = 0;
    int   stray_k = -1;
    logic [5:0] cnts [0:16];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mv(input int op, inout int px, inout int py);
        case (op)
            1: if (py > 0) py--;
            2: if (py < BN - 1) py++;
            3: if (px > 0) px--;
            4: if (px < BN - 1) px++;
            default: ;
        endcase
    endtask

    task automatic push(input int k, input int ex, input int ey, input int eop);
        ev_t e;
        e.kind = k; e.ex = ex; e.ey = ey; e.eop = eop; e.escore = mscore;
        expq.push_back(e);
    endtask

    task automatic add_score(input int cnt, input int c);
`ifdef COMBO_SCORE_EN
        mscore = mscore + cnt * (c + 1);
`else
        mscore = mscore + cnt;
`endif
        if (mscore > 65535) mscore = 65535;
    endtask

    task automatic pop_check(input int k);
        ev_t e;
        if (expq.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL unexpected_event: got kind %0d expected none at %0t", k, $time);
            return;
        end
        e = expq.pop_front();
        check("event_kind", k, e.kind);
        if (e.kind == 0 || e.kind == 4 || e.kind == 5) begin
            check("event_x", int'(x), e.ex);
            check("event_y", int'(y), e.ey);
        end
        if (e.kind == 0 || e.kind == 4) check("event_swap_op", int'(swap_op), e.eop);
        if (e.kind == 5) begin
            check("end_score", int'(score), e.escore);
            check("end_selected", int'(selected), 0);
        end
    endtask

    // Monitor: every observed start pulse or busy fall consumes one expected event.
    initial begin
        bit prev_busy;
        prev_busy = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) prev_busy = 0;
            else begin
                if (swap_start)   pop_check(0);
                if (match_start)  pop_check(1);
                if (elim_start)   pop_check(2);
                if (drop_start)   pop_check(3);
                if (revert_start) pop_check(4);
                if (prev_busy && !busy) pop_check(5);
                prev_busy = busy;
            end
        end
    end

    function automatic bit start_of(input int k);
        case (k)
            0: return swap_start;
            1: return match_start;
            2: return elim_start;
            3: return drop_start;
            default: return revert_start;
        endcase
    endfunction

    task automatic set_done(input int k, input bit v, input bit r1, input logic [5:0] cnt);
        case (k)
            0: begin swap_done = v; moved = v & r1; end
            1: begin match_done = v; match_found = v & r1; match_count = v ? cnt : 6'd0; end
            2: elim_done = v;
            3: drop_done = v;
            default: revert_done = v;
        endcase
    endtask

    task automatic noise(input int k);
        op_valid = 1'($urandom_range(0, 1));
        op_code  = 4'($urandom_range(0, 7));
        stray_k  = -1;
        if ($urandom_range(0, 2) == 0) begin
            stray_k = (k + 1 + int'($urandom_range(0, 3))) % 5;
            set_done(stray_k, 1, 1'($urandom_range(0, 1)), 6'($urandom_range(1, 63)));
        end
    endtask

    task automatic clear_noise();
        op_valid = 0;
        op_code  = '0;
        if (stray_k >= 0) set_done(stray_k, 0, 0, 6'd0);
        stray_k = -1;
    endtask

    task automatic wait_start(input int k, output bit seen);
        int n;
        n = 0;
        while (!start_of(k) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        seen = start_of(k);
    endtask

    // Plays the datapath side of one handshake, with an optional same-cycle done probe.
    task automatic applyStimulus(input drv_t d);
        bit seen;
        if (tmo) return;
        wait_start(d.kind, seen);
        if (!seen) begin
            total++; bad++;
            $display("[TB] FAIL start_timeout: got no pulse, expected start kind %0d", d.kind);
            tmo = 1;
            return;
        end
        if ($urandom_range(0, 2) == 0) set_done(d.kind, 1, ~d.r1, ~d.cnt);
        noise(d.kind);
        @(posedge clk); #1;
        set_done(d.kind, 0, 0, 6'd0);
        clear_noise();
        repeat ($urandom_range(0, 2)) begin
            noise(d.kind);
            @(posedge clk); #1;
            clear_noise();
        end
        set_done(d.kind, 1, d.r1, d.cnt);
        @(posedge clk); #1;
        set_done(d.kind, 0, 0, 6'd0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        op_valid = 0; op_code = '0;
        for (int k = 0; k < 5; k++) set_done(k, 0, 0, 6'd0);
        expq.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_xy", int'({x, y}), 0);
        check("rst_score", int'(score), 0);
        check("rst_misc", int'({selected, swap_op, busy, swap_start, match_start,
                                elim_start, drop_start, revert_start}), 0);
        rst_n = 1;
        mx = 0; my = 0; mscore = 0; msel = 0; tmo = 0;
    endtask

    task automatic checkOutput(input int op);
        op_valid = 1; op_code = 4'(op);
        @(posedge clk); #1;
        op_valid = 0; op_code = '0;
        if (op == 5) msel = !msel;
        else if (op >= 1 && op <= 4 && !msel) mv(op, mx, my);
        check("idle_x", int'(x), mx);
        check("idle_y", int'(y), my);
        check("idle_sel", int'(selected), int'(msel));
        check("idle_busy", int'(busy), 0);
    endtask

    task automatic run_turn(input int dir, input bit mvd, input int nfound, input bit fixed);
        int ox, oy, c;
        bit fin;
        logic [5:0] cnt;
        if (!msel) checkOutput(5);
        ox = mx; oy = my;
        drv.delete();
        push(0, ox, oy, dir);
        drv.push_back('{0, mvd, 6'd0});
        msel = 0;
        if (mvd) begin
            mv(dir, mx, my);
            c = 0; fin = 0;
            while (!fin) begin
                cnt = fixed ? cnts[c] : 6'($urandom_range(0, 63));
                push(1, 0, 0, 0);
                if (c < nfound) begin
                    drv.push_back('{1, 1'b1, cnt});
                    add_score(int'(cnt), c);
                    push(2, 0, 0, 0); drv.push_back('{2, 1'b0, 6'd0});
                    push(3, 0, 0, 0); drv.push_back('{3, 1'b0, 6'd0});
                    if (c == MAXC) fin = 1;
                    else c++;
                end else begin
                    drv.push_back('{1, 1'b0, cnt});
                    if (c == 0) begin
                        push(4, mx, my, dir);
                        drv.push_back('{4, 1'b0, 6'd0});
                        mx = ox; my = oy;
                    end
                    fin = 1;
                end
            end
        end
        push(5, mx, my, 0);
        op_valid = 1; op_code = 4'(dir);
        @(posedge clk); #1;
        op_valid = 0; op_code = '0;
        foreach (drv[i]) applyStimulus(drv[i]);
        @(posedge clk); #1;
        if (tmo) do_reset();
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit seen;
        int op;
        for (int i = 0; i < 17; i++) cnts[i] = 6'd0;
        do_reset();

        // Cursor saturation at the origin, then walk down.
        checkOutput(1);
        checkOutput(3);
        repeat (3) checkOutput(2);
        check("walk_down_y", int'(y), 3);

        // Unmatched swap reverts; then a two-match cascade.
        run_turn(4, 1, 0, 0);
        check("revert_score", int'(score), 0);
        cnts[0] = 6'd3; cnts[1] = 6'd4;
        run_turn(1, 1, 2, 1);
`ifdef COMBO_SCORE_EN
        check("cascade_score", int'(score), 11);
`else
        check("cascade_score", int'(score), 7);
`endif
        // Full cascade hitting the cap, and a no-move swap.
        run_turn(3, 1, 16, 0);
        run_turn(2, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 4)) begin
                op = int'($urandom_range(0, 7));
                if (msel && op >= 1 && op <= 4) op = 6;
                checkOutput(op);
            end
            if ($urandom_range(0, 4) == 0) begin
                set_done(int'($urandom_range(0, 4)), 1, 1, 6'd9);
                @(posedge clk); #1;
                for (int k = 0; k < 5; k++) set_done(k, 0, 0, 6'd0);
                check("idle_stray_busy", int'(busy), 0);
            end
            run_turn(int'($urandom_range(1, 4)), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 5) == 0) ? 16 : int'($urandom_range(0, 3)), 0);
        end

        // Reset asserted while ELIM is outstanding.
        if (!msel) checkOutput(5);
        push(0, mx, my, 4); push(1, 0, 0, 0); push(2, 0, 0, 0);
        op_valid = 1; op_code = 4'd4;
        @(posedge clk); #1;
        op_valid = 0; op_code = '0;
        applyStimulus('{0, 1'b1, 6'd0});
        applyStimulus('{1, 1'b1, 6'd5});
        wait_start(2, seen);
        check("elim_seen", int'(seen), 1);
        @(negedge clk); #1;
        rst_n = 0;
        #1;
        check("async_busy", int'(busy), 0);
        check("async_score", int'(score), 0);
        check("async_elim_start", int'(elim_start), 0);
        check("abort_queue", expq.size(), 0);
        expq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        mx = 0; my = 0; mscore = 0; msel = 0;
        repeat (12) @(posedge clk);
        #1;
        check("post_abort_busy", int'(busy), 0);

        // Drive the score to the ceiling.
        for (int i = 0; i < 17; i++) cnts[i] = 6'd63;
        while (mscore < 16'hFFF0)
            run_turn(2 + 2 * int'($urandom_range(0, 1)), 1,
                     (mscore < 16'hFFF0 - 9000) ? 16 : 1, 1);
        cnts[0] = 6'd40;
        run_turn(1, 1, 1, 1);
        check("sat_score", int'(score), 16'hFFFF);
        run_turn(3, 1, 1, 1);
        check("sat_hold", int'(score), 16'hFFFF);

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
